// File: rtl/neuron_mac.sv
// neuron_mac: streaming Q8.8 multiply-accumulate with bias, rescale and 16-bit saturation.
// Define NEURON_ROUND_EN to round half toward +inf in SCALE instead of floor.
module neuron_mac #(
    parameter int NUM_INPUTS = 8,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [15:0] bias_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] data_in,
    input  logic [15:0] weight_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sum_out,
    output logic        busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] SCALE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam int CW = $clog2(NUM_INPUTS + 1);

    logic [1:0]                  state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [15:0]                 bias_q, bias_d;
    logic [15:0]                 sum_q, sum_d;
    logic signed [31:0]          prod;
    logic signed [ACC_WIDTH-1:0] prod_ext, bias_ext, rnd, t, r;

    assign prod     = $signed(data_in) * $signed(weight_in);
    assign prod_ext = {{(ACC_WIDTH-32){prod[31]}}, prod};
    assign bias_ext = {{(ACC_WIDTH-16){bias_q[15]}}, bias_q};
`ifdef NEURON_ROUND_EN
    assign rnd = ACC_WIDTH'(1) <<< (FRAC_BITS - 1);
`else
    assign rnd = '0;
`endif
    assign t = acc_q + (bias_ext <<< FRAC_BITS) + rnd;
    assign r = t >>> FRAC_BITS;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        bias_d  = bias_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: if (start) begin
                bias_d  = bias_in;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ACCUM;
            end
            ACCUM: if (in_valid) begin
                acc_d   = acc_q + prod_ext;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(NUM_INPUTS - 1)) ? SCALE : ACCUM;
            end
            SCALE: begin
                sum_d   = (r > ACC_WIDTH'(32767))  ? 16'h7FFF :
                          (r < ACC_WIDTH'(-32768)) ? 16'h8000 : r[15:0];
                state_d = DONE;
            end
            default: state_d = out_ready ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            bias_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            bias_q  <= bias_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum_out   = sum_q;
endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Multiply-accumulate neuron stage directly upstream of the activation LUT.
- Streams NUM_INPUTS signed Q8.8 input/weight pairs, accumulates at full precision, adds a Q8.8 bias, and rescales to Q8.8.
- Saturates to a 16-bit pre-activation value and presents it with a valid/ready handshake.
- sum_out connects directly to the activation block's 16-bit input.

Parameters:
- NUM_INPUTS, 8, number of input/weight beats per neuron evaluation (min 1).
- FRAC_BITS, 8, fractional bits of the Q-format for input, weight, bias and output.
- ACC_WIDTH, 40, signed accumulator width. Must be at least 32 + ceil(log2(NUM_INPUTS)).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- n_rst  in  1  synchronous active-low reset.
- start  in  1  begin a new evaluation; sampled only in IDLE.
- bias_in  in  16  signed Q8.8 bias; latched on the start edge.
- in_valid  in  1  data_in/weight_in pair valid.
- in_ready  out  1  block accepts a pair this cycle.
- data_in  in  16  signed Q8.8 input sample.
- weight_in  in  16  signed Q8.8 weight.
- out_valid  out  1  sum_out holds a completed result.
- out_ready  in  1  downstream accepts the result.
- sum_out  out  16  signed Q8.8 saturated pre-activation.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: n_rst low at a rising edge clears all state.
  - Outputs: in_ready=0, out_valid=0, sum_out=0x0000, busy=0.
  - Internals: accumulator=0, beat counter=0, state=IDLE.
  - Reset has priority over every other input and aborts any evaluation in progress; no partial result is ever emitted.
- State machine: IDLE -> ACCUM -> SCALE -> DONE -> IDLE.
- IDLE:
  - start=1: latch bias_in, clear accumulator and counter, go to ACCUM.
  - start=0: stay in IDLE.
  - in_valid is ignored in IDLE, including when it arrives with start.
- ACCUM:
  - in_ready=1.
  - A beat is accepted on an edge where in_valid & in_ready.
  - On each accepted beat: accumulator += sign-extended (data_in * weight_in). The product is a 32-bit signed Q16.16 value.
  - The counter increments per accepted beat.
  - On the edge accepting beat NUM_INPUTS, go to SCALE; in_ready drops the following cycle.
  - Gaps in in_valid are allowed and add no beats; the state stays ACCUM.
- SCALE (exactly one cycle):
  - t = accumulator + (sign-extended bias << FRAC_BITS).
  - r = t >>> FRAC_BITS (arithmetic shift, floor).
  - If r > 32767, sum_out = 0x7FFF; if r < -32768, sum_out = 0x8000; otherwise sum_out = r[15:0].
  - sum_out is registered on the SCALE->DONE edge, and out_valid rises on that same edge.
- Latency: out_valid is high starting one rising edge after the edge that accepted the last beat.
- DONE:
  - out_valid=1; sum_out is held stable while out_ready=0.
  - start is ignored.
  - On an edge with out_ready=1, go to IDLE and clear out_valid. sum_out keeps its last value.
  - A start in the same cycle as the handshake is not accepted. The earliest new start is sampled in IDLE on the next edge.
- Internal overflow: the accumulator never wraps for legal ACC_WIDTH. Saturation is applied only once, in SCALE.
- NUM_INPUTS=1: a single accepted beat moves ACCUM directly to SCALE.

Optional Feature:
- Macro: NEURON_ROUND_EN.
- Defined: SCALE adds 1 << (FRAC_BITS-1) to t before the arithmetic shift (round half toward +infinity), then saturates.
- Undefined: plain floor truncation, as described in Behaviour.
- Latency and handshake are identical in both builds.

Test Plan:
- Basic sum: NUM_INPUTS=4, bias 0x0000, four beats of 0x0100 * 0x0100 -> out_valid one edge after beat 4, sum_out=0x0400.
- Bias and gaps: four beats of 0x0080 * 0x0100 with in_valid low for 2 cycles between beats 2 and 3, bias 0xFF00 -> sum_out=0x0100; in_ready is high throughout ACCUM.
- Saturation:
  - Four beats of 0x7FFF * 0x7FFF -> sum_out=0x7FFF.
  - Four beats of 0x8000 * 0x7FFF -> sum_out=0x8000.
- Rounding: beats 0x0001*0x0080, then three of 0*0:
  - Without NEURON_ROUND_EN -> sum_out=0x0000.
  - With NEURON_ROUND_EN -> sum_out=0x0001.
  - Same test with 0xFFFF*0x0080 -> 0xFFFF without the macro, 0x0000 with it.
- Backpressure: out_ready held low 5 cycles with start pulsed in DONE -> out_valid and sum_out constant, no new evaluation starts. out_ready high for one edge -> IDLE, out_valid=0, busy=0.
- Reset mid-operation: n_rst low for one edge after 2 accepted beats -> all outputs at reset values. A fresh 4-beat run of 0x0100*0x0100 then yields exactly 0x0400.
